// File: rtl/csram_controller.sv
// rtl/csram_controller.sv - CSRAM port sequencer for one neuron core
// Arbitrates row loads against the tick-driven read/update/write-back sweep.
module csram_controller #(
  parameter int NUM_NEURONS = 256,
  parameter int WIDTH       = 368,
  parameter int POT_INDEX   = 103,
  parameter int POT_WIDTH   = 9
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           tick,
  input  logic                           load_valid,
  output logic                           load_ready,
  input  logic [$clog2(NUM_NEURONS)-1:0] load_addr,
  input  logic [WIDTH-1:0]               load_data,
  output logic                           csram_en,
  output logic                           csram_we,
  output logic [$clog2(NUM_NEURONS)-1:0] csram_addr,
  output logic [WIDTH-1:0]               csram_di,
  input  logic [WIDTH-1:0]               csram_dout,
  output logic                           neuron_valid,
  output logic [$clog2(NUM_NEURONS)-1:0] neuron_addr,
  output logic [WIDTH-1:0]               neuron_data,
  input  logic                           upd_valid,
  input  logic [POT_WIDTH-1:0]           upd_potential,
  output logic                           busy,
  output logic                           done,
  output logic                           overrun
);

  localparam int AW = $clog2(NUM_NEURONS);
  localparam logic [AW-1:0] LAST = AW'(NUM_NEURONS - 1);

  typedef enum logic [2:0] {IDLE, RD, LATCH, PRES, WB, DONE} state_t;

  state_t          state;
  logic [AW-1:0]   counter;
  logic [WIDTH-1:0] row_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      counter <= '0;
      row_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tick) begin
            state   <= RD;
            counter <= '0;
          end
        end
        RD:    state <= LATCH;
        LATCH: begin
          row_q <= csram_dout;
          state <= PRES;
        end
        PRES: begin
          if (upd_valid) begin
            row_q[POT_INDEX +: POT_WIDTH] <= upd_potential;
            state <= WB;
          end
        end
        WB: begin
          if (counter == LAST) begin
            state <= DONE;
          end else begin
            counter <= counter + 1'b1;
            state   <= RD;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Port decode is gated by rst so the reset cycle can never write the array.
  always_comb begin
    load_ready   = 1'b0;
    csram_en     = 1'b0;
    csram_we     = 1'b0;
    csram_addr   = '0;
    csram_di     = '0;
    neuron_valid = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          load_ready = ~tick;
          if (load_valid && !tick) begin
            csram_en   = 1'b1;
            csram_we   = 1'b1;
            csram_addr = load_addr;
            csram_di   = load_data;
          end
        end
        RD: begin
          csram_en   = 1'b1;
          csram_addr = counter;
        end
        PRES: neuron_valid = 1'b1;
        WB: begin
          csram_en   = 1'b1;
          csram_we   = 1'b1;
          csram_addr = counter;
          csram_di   = row_q;
        end
        default: ;
      endcase
    end
  end

  assign neuron_addr = counter;
  assign neuron_data = row_q;
  assign busy        = !rst && (state != IDLE);
  assign done        = !rst && (state == DONE);
  assign overrun     = !rst && tick && (state != IDLE);

endmodule

// File: tb/tb_csram_controller.sv
// tb/tb_csram_controller.sv - directed bench for csram_controller
// Holds a behavioural CSRAM and plays the neuron block from the test tasks.
module tb_csram_controller;

  localparam int NUM_NEURONS = 256;
  localparam int WIDTH       = 368;
  localparam int POT_INDEX   = 103;
  localparam int POT_WIDTH   = 9;
  localparam int AW          = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 tick = 1'b0;
  logic                 load_valid = 1'b0;
  logic                 load_ready;
  logic [AW-1:0]        load_addr = '0;
  logic [WIDTH-1:0]     load_data = '0;
  logic                 csram_en;
  logic                 csram_we;
  logic [AW-1:0]        csram_addr;
  logic [WIDTH-1:0]     csram_di;
  logic [WIDTH-1:0]     csram_dout;
  logic                 neuron_valid;
  logic [AW-1:0]        neuron_addr;
  logic [WIDTH-1:0]     neuron_data;
  logic                 upd_valid = 1'b0;
  logic [POT_WIDTH-1:0] upd_potential = '0;
  logic                 busy;
  logic                 done;
  logic                 overrun;

  logic [WIDTH-1:0] mem [NUM_NEURONS];

  int n_cmp = 0;
  int n_bad = 0;

  csram_controller #(
    .NUM_NEURONS(NUM_NEURONS), .WIDTH(WIDTH), .POT_INDEX(POT_INDEX), .POT_WIDTH(POT_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr), .load_data(load_data),
    .csram_en(csram_en), .csram_we(csram_we), .csram_addr(csram_addr), .csram_di(csram_di),
    .csram_dout(csram_dout),
    .neuron_valid(neuron_valid), .neuron_addr(neuron_addr), .neuron_data(neuron_data),
    .upd_valid(upd_valid), .upd_potential(upd_potential),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Write-first, one-cycle registered read.
  always @(posedge clk) begin
    if (csram_en) begin
      if (csram_we) begin
        mem[csram_addr] <= csram_di;
        csram_dout      <= csram_di;
      end else begin
        csram_dout <= mem[csram_addr];
      end
    end
  end

  function automatic logic [WIDTH-1:0] pat(input int i);
    logic [7:0]       b;
    logic [WIDTH-1:0] r;
    b = 8'(i) ^ 8'h5A;
    r = {46{b}};
    r[POT_INDEX +: POT_WIDTH] = 9'(i);
    return r;
  endfunction

  task automatic bulk_load(output int errs);
    errs = 0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      @(negedge clk);
      load_valid = 1'b1;
      load_addr  = 8'(i);
      load_data  = pat(i);
      #1;
      if (!(load_ready && csram_en && csram_we)) errs++;
    end
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  // mode 0: potential 0, mode 1: field+1, mode 2: constant 9'h1AB
  task automatic run_sweep(input int stall_addr, input int stall_len, input int mode,
                           input int tick2_at, input int rst_addr,
                           output int cycles, output int n_done, output int n_over,
                           output int errs, output int hit_rst);
    int               idx;
    int               stall_cnt;
    logic [WIDTH-1:0] held;
    logic [POT_WIDTH-1:0] f;
    cycles = -1; n_done = 0; n_over = 0; errs = 0; hit_rst = 0;
    idx = 0; stall_cnt = 0; held = '0;
    @(negedge clk);
    tick = 1'b1;
    #1;
    if (load_valid && load_ready) errs++;
    if (csram_en) errs++;
    @(negedge clk);
    for (int cyc = 1; cyc <= 1200; cyc++) begin
      upd_valid = 1'b0;
      tick      = (cyc == tick2_at);
      if (rst_addr >= 0 && busy && csram_we && csram_addr == 8'(rst_addr)) begin
        rst = 1'b1;
        hit_rst = 1;
        break;
      end
      if (neuron_valid) begin
        if (neuron_addr !== 8'(idx)) errs++;
        if (csram_en) errs++;
        if (stall_addr >= 0 && neuron_addr == 8'(stall_addr) && stall_cnt < stall_len) begin
          if (stall_cnt == 0) held = neuron_data;
          else if (neuron_data !== held) errs++;
          stall_cnt++;
        end else begin
          f = neuron_data[POT_INDEX +: POT_WIDTH];
          if (mode == 0)      upd_potential = '0;
          else if (mode == 1) upd_potential = f + 1'b1;
          else                upd_potential = 9'h1AB;
          upd_valid = 1'b1;
          idx++;
        end
      end
      #1;
      if (load_valid && load_ready) errs++;
      if (overrun) n_over++;
      if (done) begin
        n_done++;
        cycles = cyc;
        break;
      end
      @(negedge clk);
    end
    if (hit_rst == 0) begin
      @(negedge clk);
      tick      = 1'b0;
      upd_valid = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; tick = 1'b1; load_valid = 1'b1; load_addr = 8'd3;
    @(negedge clk); @(negedge clk);
    #1;
    n_cmp++; if (csram_en !== 1'b0) begin n_bad++; $display("FAIL reset_csram_en: got %0b want 0", csram_en); end
    n_cmp++; if (load_ready !== 1'b0) begin n_bad++; $display("FAIL reset_load_ready: got %0b want 0", load_ready); end
    n_cmp++; if ({busy, done, overrun, neuron_valid} !== 4'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b want 0000", {busy, done, overrun, neuron_valid});
    end
    @(negedge clk);
    rst = 1'b0; tick = 1'b0; load_valid = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || neuron_addr !== 8'd0 || neuron_data !== '0) begin
      n_bad++; $display("FAIL reset_state: busy %0b addr %0d want 0/0 and zero row", busy, neuron_addr);
    end
  endtask

  task automatic test_readback;
    int errs, cyc, nd, no, hr, bad_rows;
    logic [WIDTH-1:0] exp;
    bulk_load(errs);
    n_cmp++; if (errs != 0) begin n_bad++; $display("FAIL bulk_load: %0d rejected want 0", errs); end
    run_sweep(-1, 0, 1, -1, -1, cyc, nd, no, errs, hr);
    n_cmp++; if (cyc != 1025) begin n_bad++; $display("FAIL readback_cycles: got %0d want 1025", cyc); end
    n_cmp++; if (errs != 0) begin n_bad++; $display("FAIL readback_sequence: %0d errors want 0", errs); end
    bad_rows = 0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      exp = pat(i);
      exp[POT_INDEX +: POT_WIDTH] = 9'(i + 1);
      if (mem[i] !== exp) bad_rows++;
    end
    n_cmp++; if (bad_rows != 0) begin n_bad++; $display("FAIL readback_rows: %0d wrong rows want 0", bad_rows); end
  endtask

  task automatic test_load_sweep;
    int errs, cyc, nd, no, hr;
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] exp;
    ones = '1;
    exp  = ones;
    exp[POT_INDEX +: POT_WIDTH] = '0;
    @(negedge clk);
    load_valid = 1'b1; load_addr = 8'd5; load_data = ones;
    #1;
    n_cmp++; if (load_ready !== 1'b1) begin n_bad++; $display("FAIL load_ready: got %0b want 1", load_ready); end
    n_cmp++; if ({csram_en, csram_we} !== 2'b11 || csram_addr !== 8'd5 || csram_di !== ones) begin
      n_bad++; $display("FAIL load_port: en/we %b addr %0d want 11 / 5", {csram_en, csram_we}, csram_addr);
    end
    @(negedge clk);
    load_valid = 1'b0;
    run_sweep(-1, 0, 0, -1, -1, cyc, nd, no, errs, hr);
    n_cmp++; if (cyc != 1025) begin n_bad++; $display("FAIL sweep_cycles: got %0d want 1025", cyc); end
    n_cmp++; if (nd != 1 || no != 0) begin n_bad++; $display("FAIL sweep_pulses: done %0d overrun %0d want 1/0", nd, no); end
    n_cmp++; if (mem[5] !== exp) begin n_bad++; $display("FAIL row5: got %h want %h", mem[5], exp); end
  endtask

  task automatic test_backpressure;
    int errs, cyc, nd, no, hr;
    run_sweep(3, 7, 0, -1, -1, cyc, nd, no, errs, hr);
    n_cmp++; if (cyc != 1032) begin n_bad++; $display("FAIL stall_cycles: got %0d want 1032", cyc); end
    n_cmp++; if (errs != 0) begin n_bad++; $display("FAIL stall_stability: %0d errors want 0", errs); end
  endtask

  task automatic test_arbitration;
    int errs, cyc, nd, no, hr;
    logic [WIDTH-1:0] x;
    x = {46{8'hC3}};
    load_valid = 1'b1; load_addr = 8'd20; load_data = x;
    run_sweep(-1, 0, 0, -1, -1, cyc, nd, no, errs, hr);
    n_cmp++; if (errs != 0) begin n_bad++; $display("FAIL arb_load_blocked: %0d errors want 0", errs); end
    n_cmp++; if (cyc != 1025) begin n_bad++; $display("FAIL arb_cycles: got %0d want 1025", cyc); end
    #1;
    n_cmp++; if (load_ready !== 1'b1 || csram_we !== 1'b1) begin
      n_bad++; $display("FAIL arb_first_idle: ready %0b we %0b want 1/1", load_ready, csram_we);
    end
    @(negedge clk);
    load_valid = 1'b0;
    n_cmp++; if (mem[20] !== x) begin n_bad++; $display("FAIL arb_row20: got %h want %h", mem[20], x); end
  endtask

  task automatic test_overrun;
    int errs, cyc, nd, no, hr;
    run_sweep(-1, 0, 0, 100, -1, cyc, nd, no, errs, hr);
    n_cmp++; if (no != 1) begin n_bad++; $display("FAIL overrun_mid: got %0d pulses want 1", no); end
    n_cmp++; if (nd != 1 || cyc != 1025) begin n_bad++; $display("FAIL overrun_timing: done %0d at %0d want 1 at 1025", nd, cyc); end
    @(negedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL overrun_idle: busy %0b want 0", busy); end
    run_sweep(-1, 0, 0, 1025, -1, cyc, nd, no, errs, hr);
    n_cmp++; if (no != 1 || cyc != 1025) begin n_bad++; $display("FAIL overrun_done: %0d pulses at %0d want 1 at 1025", no, cyc); end
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL overrun_done_ignored: busy %0b want 0", busy); end
  endtask

  task automatic test_reset_midsweep;
    int errs, cyc, nd, no, hr, bad_rows;
    logic [WIDTH-1:0] exp;
    bulk_load(errs);
    run_sweep(-1, 0, 2, -1, 10, cyc, nd, no, errs, hr);
    n_cmp++; if (hr != 1) begin n_bad++; $display("FAIL rst_reach_wb10: got %0d want 1", hr); end
    #1;
    n_cmp++; if (csram_en !== 1'b0) begin n_bad++; $display("FAIL rst_csram_en: got %0b want 0", csram_en); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %0b want 0", busy); end
    bad_rows = 0;
    for (int i = 0; i < 10; i++) begin
      exp = pat(i);
      exp[POT_INDEX +: POT_WIDTH] = 9'h1AB;
      if (mem[i] !== exp) bad_rows++;
    end
    n_cmp++; if (bad_rows != 0) begin n_bad++; $display("FAIL rst_rows_kept: %0d wrong rows want 0", bad_rows); end
    n_cmp++; if (mem[10] !== pat(10) || mem[11] !== pat(11)) begin
      n_bad++; $display("FAIL rst_row10: got %h want %h", mem[10], pat(10));
    end
  endtask

  initial begin
    test_reset();
    test_readback();
    test_load_sweep();
    test_backpressure();
    test_arbitration();
    test_overrun();
    test_reset_midsweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/csram_controller.md
Name: csram_controller

Overview:
Sequences the core SRAM (CSRAM: one WIDTH-bit row per neuron, 1-cycle registered read, write-first) for one neuron core.
It arbitrates between two users of the single CSRAM port:
- a configuration loader that writes whole rows;
- a tick-driven sweep that, for every neuron, reads the row, hands it to the neuron block, and writes back the updated membrane-potential field.
It sits between the CSRAM instance and the core's neuron block and tick logic.

Parameters:
NUM_NEURONS, 256, number of CSRAM rows / neurons per core
WIDTH, 368, CSRAM row width in bits
POT_INDEX, 103, LSB position of the potential field within a row
POT_WIDTH, 9, width of the potential field

Ports:
clk  input  1  core clock; all logic on its rising edge
rst  input  1  synchronous, active-high reset
tick  input  1  single-cycle pulse; starts a sweep over all neurons
load_valid  input  1  loader requests a full-row write
load_ready  output  1  loader write accepted this cycle (valid & ready)
load_addr  input  clog2(NUM_NEURONS)  loader row address
load_data  input  WIDTH  loader row data
csram_en  output  1  CSRAM enable
csram_we  output  1  CSRAM write enable
csram_addr  output  clog2(NUM_NEURONS)  CSRAM address
csram_di  output  WIDTH  CSRAM write data
csram_dout  input  WIDTH  CSRAM read data, valid the cycle after a read is issued
neuron_valid  output  1  neuron_addr / neuron_data valid; held until upd_valid
neuron_addr  output  clog2(NUM_NEURONS)  index of the neuron being processed
neuron_data  output  WIDTH  full row of the current neuron
upd_valid  input  1  neuron block returns its result; sampled only while neuron_valid=1
upd_potential  input  POT_WIDTH  new potential for the current neuron
busy  output  1  sweep in progress (state != IDLE)
done  output  1  one-cycle pulse when the sweep completes
overrun  output  1  one-cycle pulse when tick arrives while busy

Behaviour:
- Reset:
  - State goes to IDLE; neuron counter, row register and all outputs go to 0.
  - While rst=1, csram_en=0 and load_ready=0, regardless of state, so no CSRAM write occurs in the reset cycle.
  - CSRAM contents are not cleared.
  - Reset mid-sweep abandons the sweep; rows already written back stay written.
- FSM states: IDLE, RD, LATCH, PRES, WB, DONE.
- IDLE:
  - load_ready = ~tick.
  - If load_valid & load_ready, drive csram_en=1, csram_we=1, csram_addr=load_addr, csram_di=load_data in the same cycle (combinational).
  - If tick=1: go to RD, counter=0. Tick has priority over a same-cycle load; that load is not accepted and must be held.
- RD: csram_en=1, csram_we=0, csram_addr=counter. Next state is LATCH.
- LATCH: row_q <= csram_dout. Next state is PRES.
- PRES:
  - neuron_valid=1, neuron_addr=counter, neuron_data=row_q.
  - Stays in PRES while upd_valid=0.
  - On upd_valid: row_q[POT_INDEX +: POT_WIDTH] <= upd_potential, all other bits unchanged; go to WB.
- WB:
  - csram_en=1, csram_we=1, csram_addr=counter, csram_di=row_q.
  - If counter == NUM_NEURONS-1, go to DONE; otherwise counter+1 and go to RD.
- DONE: done=1 for one cycle, then go to IDLE.
- Outside the states named above, csram_en=0, csram_we=0, neuron_valid=0, load_ready=0.
- Loads are never accepted while busy.
- Timing: minimum 4 cycles per neuron (RD, LATCH, PRES, WB). A sweep with zero-wait updates takes 4*NUM_NEURONS+1 cycles from tick to the done pulse.
- tick while busy: ignored; overrun=1 that cycle; the sweep continues unaffected.
- tick in the DONE cycle counts as busy, so it is ignored and overrun pulses.
- upd_valid outside PRES is ignored.
- Counter does not wrap: the sweep ends at NUM_NEURONS-1 with no extra access.

Test Plan:
- Load then sweep: load row 5 = all-ones, tick, respond upd_potential=9'h000 for every neuron → CSRAM row 5 = all-ones except bits [111:103]=0. done pulses exactly 1025 cycles after tick (NUM_NEURONS=256).
- Per-neuron readback: preload row i with i in the potential field, and respond upd_potential = neuron_data field + 1 → after done, every row's field = i+1 and all bits outside the field are unchanged.
- Backpressure: hold upd_valid low for 7 cycles on neuron 3 → neuron_valid, neuron_addr=3 and neuron_data stay stable; no CSRAM access during the stall; the sweep finishes 7 cycles later than nominal.
- Arbitration: load_valid and tick asserted in the same IDLE cycle → load_ready=0, the sweep starts. load_valid held during the sweep → never accepted until after done, then written on the first IDLE cycle.
- Overrun: second tick 100 cycles into a sweep → overrun=1 for one cycle; done count = 1; timing unchanged.
- Reset mid-sweep: assert rst for one cycle while in WB at neuron 10 → csram_en=0 that cycle; row 10 is not written; busy=0 next cycle; rows 0-9 keep their updated values.
